// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: dmem-port UART transmitter, stores to TX_ADDR queue bytes sent 8N1 on tx
module mmio_uart_tx #(
  parameter logic [11:0] TX_ADDR    = 12'hFF0,
  parameter logic [11:0] STAT_ADDR  = 12'hFF1,
  parameter int unsigned BAUD_DIV   = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic [31:0] q_dmem,
  output logic        wren_mem,
  output logic [31:0] q_proc,
  output logic        tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, ovf_q, ovf_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic sel_tx, sel_stat, push_req, push, pop, empty, baud_end;
  logic unused_data;
  assign unused_data = ^data[31:8];
  assign sel_tx    = address_dmem == TX_ADDR;
  assign sel_stat  = address_dmem == STAT_ADDR;
  assign push_req  = wren && sel_tx;
  assign empty     = cnt_q == '0;
  assign baud_end  = baud_q == BAUD_LAST;
  // a full FIFO still accepts a byte when the transmitter frees a slot this cycle
  assign push      = push_req && (cnt_q != DEPTH || pop);
  assign wren_mem  = wren && !sel_tx && !sel_stat;
  assign q_proc    = sel_stat ? {28'd0, empty, ovf_q, full_q, tx_busy} : q_dmem;
  assign tx        = tx_q;
  assign tx_busy   = state_q != IDLE;
  assign fifo_full = full_q;
  assign overflow  = ovf_q;
  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          shift_d = mem_q[rd_q];
        end
      end
      START: if (baud_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (baud_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (baud_end) begin
        state_d = empty ? IDLE : START;
        pop     = !empty;
        shift_d = empty ? shift_q : mem_q[rd_q];
      end
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_comb begin
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ovf_d = (push_req && !push) ? 1'b1 : (wren && sel_stat) ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      full_q  <= cnt_d == DEPTH;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= data[7:0];
  end
endmodule
